dot_product_sequencer: RTL



---
 rtl/dot_product_sequencer_pkg.sv | 31 +++
 rtl/dot_product_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: array op codes, FSM states
// and the result-width rule.
package dot_product_sequencer_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RD_LAT    = 2;

    function automatic int unsigned res_width(input int unsigned data_w, input int unsigned lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    localparam int unsigned RES_W = res_width(DATA_W, NUM_LANES);

    typedef enum logic [1:0] {
        OP_LOAD_W = 2'b00,
        OP_LOAD_A = 2'b01,
        OP_READ_S = 2'b10,
        OP_NOP    = 2'b11
    } arr_op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_A,
        READ,
        COLLECT,
        OUT
    } state_e;

endpackage

// File: rtl/dot_product_sequencer.sv
// Loads weights/activations into the compute-in-SRAM array, triggers one READ_S
// and reassembles the serialized result into a single valid/ready word.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_reuse_w,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [1:0]        arr_op,
    output logic [5:0]        arr_addr,
    output logic [DATA_W-1:0] arr_data,
    input  logic [DATA_W-1:0] arr_res,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RES_W-1:0]  m_data,
    output logic              busy
);

    localparam int unsigned IDX_W     = $clog2(NUM_LANES);
    localparam int unsigned RES_BYTES = (RES_W + DATA_W - 1) / DATA_W;
    localparam int unsigned CNT_W     = $clog2(RD_LAT + RES_BYTES);

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(RD_LAT + RES_BYTES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_loaded_q, w_loaded_d;
    arr_op_e            arr_op_q, arr_op_d;
    logic [5:0]         arr_addr_q, arr_addr_d;
    logic [DATA_W-1:0]  arr_data_q, arr_data_d;
    logic [RES_W-1:0]   m_data_q, m_data_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        w_loaded_d = w_loaded_q;
        arr_op_d   = OP_NOP;
        arr_addr_d = arr_addr_q;
        arr_data_d = arr_data_q;
        m_data_d   = m_data_q;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    idx_d   = '0;
                    state_d = (cfg_reuse_w && w_loaded_q) ? LOAD_A : LOAD_W;
                end
            end
            LOAD_W, LOAD_A: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    arr_op_d   = (state_q == LOAD_W) ? OP_LOAD_W : OP_LOAD_A;
                    arr_addr_d = 6'(idx_q);
                    arr_data_d = s_data;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == LAST_LANE) begin
                        idx_d = '0;
                        if (state_q == LOAD_W) begin
                            w_loaded_d = 1'b1;
                            state_d    = LOAD_A;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                arr_op_d = OP_READ_S;
                cnt_d    = '0;
                state_d  = COLLECT;
            end
            COLLECT: begin
                cnt_d = cnt_q + 1'b1;
                // MSB byte first; its unused upper bits fall off the top of the shift.
                if (cnt_q >= CAP_FIRST) begin
                    m_data_d = {m_data_q[RES_W-DATA_W-1:0], arr_res};
                end
                if (cnt_q == CAP_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            w_loaded_q <= 1'b0;
            arr_op_q   <= OP_NOP;
            arr_addr_q <= '0;
            arr_data_q <= '0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            w_loaded_q <= w_loaded_d;
            arr_op_q   <= arr_op_d;
            arr_addr_q <= arr_addr_d;
            arr_data_q <= arr_data_d;
            m_data_q   <= m_data_d;
        end
    end

    assign arr_op   = arr_op_q;
    assign arr_addr = arr_addr_q;
    assign arr_data = arr_data_q;
    assign m_data   = m_data_q;

endmodule
